// File: rtl/rs_bank_pkg.sv
// rtl/rs_bank_pkg.sv - shared types and sizing for the reservation-station banks
package rs_bank_pkg;

    localparam int PHYS_TAG_W = 6;
    localparam int ROB_IDX_W  = 5;

    localparam int RS_ALU_SZ    = 8;
    localparam int RS_MULT_SZ   = 4;
    localparam int RS_BRANCH_SZ = 4;
    localparam int RS_MEM_SZ    = 8;

    localparam int NUM_FU_ALU    = 2;
    localparam int NUM_FU_MULT   = 1;
    localparam int NUM_FU_BRANCH = 1;
    localparam int NUM_FU_MEM    = 1;

    typedef logic [PHYS_TAG_W-1:0] phys_tag_t;

    typedef enum logic [1:0] {
        RS_KIND_ALU    = 2'd0,
        RS_KIND_MULT   = 2'd1,
        RS_KIND_BRANCH = 2'd2,
        RS_KIND_MEM    = 2'd3
    } rs_kind_e;

    typedef struct packed {
        logic                 valid;
        logic [3:0]           op;
        phys_tag_t            dest_tag;
        phys_tag_t            src1_tag;
        logic                 src1_ready;
        phys_tag_t            src2_tag;
        logic                 src2_ready;
        logic [ROB_IDX_W-1:0] rob_idx;
    } rs_entry_t;

endpackage

// File: rtl/rs_free_select.sv
// rtl/rs_free_select.sv - picks the DISPATCH_W lowest free entries as one-hot vectors
module rs_free_select #(
    parameter int SIZE       = 8,
    parameter int DISPATCH_W = 2
) (
    input  logic [SIZE-1:0]                  free_i,
    output logic [DISPATCH_W-1:0][SIZE-1:0]  pick_o,
    output logic [DISPATCH_W-1:0]            found_o
);

    logic [SIZE-1:0] remain;

    // Each pick takes the lowest remaining bit, then removes it for the next pick.
    always_comb begin
        remain  = free_i;
        pick_o  = '0;
        found_o = '0;
        for (int p = 0; p < DISPATCH_W; p++) begin
            for (int i = 0; i < SIZE; i++) begin
                if (remain[i] && !found_o[p]) begin
                    pick_o[p][i] = 1'b1;
                    found_o[p]   = 1'b1;
                end
            end
            remain = remain & ~pick_o[p];
        end
    end

endmodule

// File: rtl/rs_bank.sv
// rtl/rs_bank.sv - one reservation-station bank: dispatch, CDB wakeup, issue clear
module rs_bank
    import rs_bank_pkg::*;
#(
    parameter int SIZE       = 8,
    parameter int DISPATCH_W = 2,
    parameter int CLEAR_W    = 2,
    parameter int CDB_W      = 2,
    localparam int IDX_W     = (SIZE > 1) ? $clog2(SIZE) : 1,
    localparam int CNT_W     = $clog2(SIZE + 1)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             mispredict,
    input  logic [DISPATCH_W-1:0]            disp_valid,
    input  rs_entry_t [DISPATCH_W-1:0]       disp_entry,
    input  logic [CLEAR_W-1:0]               clear_valid,
    input  logic [CLEAR_W-1:0][IDX_W-1:0]    clear_idx,
    input  logic [CDB_W-1:0]                 cdb_valid,
    input  phys_tag_t [CDB_W-1:0]            cdb_tag,
    output rs_entry_t [SIZE-1:0]             entries,
    output logic [CNT_W-1:0]                 free_count,
    output logic                             overflow
);

    rs_entry_t [SIZE-1:0]             entries_q, entries_d;
    logic [CNT_W-1:0]                 free_q, free_d;
    logic                             overflow_q, overflow_d;

    logic [SIZE-1:0]                  free_map;
    logic [SIZE-1:0]                  clr_mask;
    logic [DISPATCH_W-1:0][SIZE-1:0]  pick;
    logic [DISPATCH_W-1:0]            found;
    rs_entry_t                        new_e;

    // Allocation only sees entries free at the start of the cycle, so a slot
    // cleared this cycle cannot be reused until the next one.
    always_comb begin
        free_map = '0;
        for (int i = 0; i < SIZE; i++) begin
            free_map[i] = !entries_q[i].valid;
        end
    end

    rs_free_select #(
        .SIZE       (SIZE),
        .DISPATCH_W (DISPATCH_W)
    ) u_free_select (
        .free_i  (free_map),
        .pick_o  (pick),
        .found_o (found)
    );

    always_comb begin
        int slot;
        clr_mask = '0;
        for (int k = 0; k < CLEAR_W; k++) begin
            if (clear_valid[k]) begin
                clr_mask[clear_idx[k]] = 1'b1;
            end
        end

        entries_d = entries_q;
        for (int i = 0; i < SIZE; i++) begin
            if (clr_mask[i]) begin
                entries_d[i].valid = 1'b0;
            end else if (entries_q[i].valid) begin
                for (int c = 0; c < CDB_W; c++) begin
                    if (cdb_valid[c] && entries_q[i].src1_tag == cdb_tag[c]) begin
                        entries_d[i].src1_ready = 1'b1;
                    end
                    if (cdb_valid[c] && entries_q[i].src2_tag == cdb_tag[c]) begin
                        entries_d[i].src2_ready = 1'b1;
                    end
                end
            end
        end

        // Asserted dispatch slots are compacted: the n-th request takes pick n.
        overflow_d = overflow_q;
        slot       = 0;
        new_e      = '0;
        for (int d = 0; d < DISPATCH_W; d++) begin
            new_e       = disp_entry[d];
            new_e.valid = 1'b1;
            for (int c = 0; c < CDB_W; c++) begin
                if (cdb_valid[c] && disp_entry[d].src1_tag == cdb_tag[c]) begin
                    new_e.src1_ready = 1'b1;
                end
                if (cdb_valid[c] && disp_entry[d].src2_tag == cdb_tag[c]) begin
                    new_e.src2_ready = 1'b1;
                end
            end
            if (disp_valid[d]) begin
                for (int p = 0; p < DISPATCH_W; p++) begin
                    if (p == slot) begin
                        if (found[p]) begin
                            for (int i = 0; i < SIZE; i++) begin
                                if (pick[p][i]) begin
                                    entries_d[i] = new_e;
                                end
                            end
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
                slot = slot + 1;
            end
        end

        free_d = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (!entries_d[i].valid) begin
                free_d = free_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            entries_q  <= '0;
            free_q     <= CNT_W'(SIZE);
            overflow_q <= 1'b0;
        end else if (mispredict) begin
            entries_q  <= '0;
            free_q     <= CNT_W'(SIZE);
        end else begin
            entries_q  <= entries_d;
            free_q     <= free_d;
            overflow_q <= overflow_d;
        end
    end

    assign entries    = entries_q;
    assign free_count = free_q;
    assign overflow   = overflow_q;

endmodule
